inert_sensor_model: RTL and testbench
=====================================

// Module: inert_sensor_model
// PURPOSE
//  SPI responder (slave) model of the inertial sensor, driven by the 16-bit SPI master used by the inertial interface.
//  Decodes 16-bit frames, maintains the config register file and serves data regs 0x22..0x2B on MISO.
//  Asserts INT periodically, and snapshots the parallel rate/accel inputs, once interrupts are enabled.
//  Used as the full-chip bench stand-in for the physical sensor.
// PARAMETERS
//  INT_PERIOD  2048  clk cycles between sample/INT events once enabled (>=64)
// PORTS
//  clk      in   1   system clock
//  rst_n    in   1   asynchronous active-low reset
//  SS_n     in   1   SPI select from master, active low
//  SCLK     in   1   SPI clock from master, idle high (>=4 clk high and >=4 clk low)
//  MOSI     in   1   SPI data from master, MSB first
//  MISO     out  1   SPI data to master, MSB first
//  INT      out  1   data-ready interrupt, active high
//  ovr      out  1   sticky overrun: a sample event was lost
//  ptch_rt  in   16  pitch rate sample source
//  roll_rt  in   16  roll rate sample source
//  yaw_rt   in   16  yaw rate sample source
//  ax       in   16  X accel sample source
//  ay       in   16  Y accel sample source
// BEHAVIOUR
//  Reset: MISO=0, INT=0, ovr=0, all regs 0x00, interval counter 0, frame logic idle.
//  Sync: SS_n, SCLK and MOSI are double-flopped on clk; a third flop on SCLK/SS_n gives edge detect.
//   All SPI actions occur on the clk after the detected edge, 3 clk after the pin edge.
//  Frame states: IDLE -> SHIFT on SS_n fall -> IDLE on SS_n rise.
//  SS_n fall: bit_cnt=0, tx=8'h00, rx cleared.
//  SCLK rise in SHIFT: rx={rx[14:0],MOSI}; bit_cnt++ (saturates at 16).
//  SCLK fall in SHIFT:
//   - bit_cnt==8: tx=reg[rx[6:0]] (addr = cmd[14:8]).
//   - otherwise: tx={tx[6:0],1'b0}.
//  MISO=tx[7] while in SHIFT, 0 in IDLE. First byte returns 0x00; second byte returns the register data,
//   so the master's low byte = reg data.
//  SS_n rise with bit_cnt==16 (complete frame):
//   - rx[15]==0 (write): reg[rx[14:8]]=rx[7:0], for writable addrs only.
//   - rx[15]==1 (read) and addr==0x2B: INT cleared.
//  SS_n rise with bit_cnt!=16: frame discarded; no write, no INT clear.
//  Register map:
//   - 0x0D, 0x10, 0x11, 0x14 are R/W config.
//   - 0x22/0x23 ptch L/H, 0x24/0x25 roll, 0x26/0x27 yaw, 0x28/0x29 ax, 0x2A/0x2B ay: read-only.
//   - All other addrs read 0x00; writes to them are ignored.
//  Interrupt enable = reg[0x0D][1]:
//   - Counter runs 0..INT_PERIOD-1 while enabled and wraps; held at 0 while disabled.
//   - Clearing enable mid-count resets the counter. INT already high stays high until cleared by read.
//  Sample event (counter==INT_PERIOD-1), INT low:
//   - Sets pending. Pending is serviced on the first clk with no frame in SHIFT:
//     data regs <= inputs (L=[7:0], H=[15:8]), INT=1 same clk, pending=0.
//   - Never update data regs mid-frame.
//  Sample event with INT high or pending set: event dropped, ovr=1 (sticky until reset), data regs unchanged.
//  Simultaneous AYH-read INT clear and sample event: clear wins first, then event treated as INT low -> new snapshot.
//  Reset mid-frame: immediate return to reset state; the partial frame has no effect.
// TESTING
//  1. Reset, write 0x0D02, 0x1062, 0x1162, 0x1460, then read each -> low bytes 02, 62, 62, 60.
//     INT rises INT_PERIOD clk after the 0x0D02 commit.
//  2. Inputs ptch_rt=16'h1234 ... ay=16'hA55A; wait INT; read A2..AB -> 34,12,..,5A,A5.
//     INT falls after the AB frame's SS_n rise, not before.
//  3. Write 0x2299 and 0x3377 -> subsequent reads of 0xA2 / 0xB3 return snapshot / 0x00.
//  4. Abort a 0x0D00 write after 9 SCLKs (SS_n high) -> reg 0x0D still 0x02, INT cadence unchanged.
//  5. Never read 0xAB across 2 periods -> ovr=1, data regs keep first snapshot, INT stays 1.
//  6. Force a sample event during an active read frame -> snapshot and INT delayed to the clk after SS_n rise;
//     in-flight read returns old data.

Source files
------------

// File: rtl/inert_sensor_model_if.sv
// SPI pins between the 16-bit inertial master and the sensor responder model.
interface inert_sensor_model_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_sensor_model.sv
// SPI responder model of the inertial sensor: 16-bit frames, config regs,
// read-only sample regs 0x22..0x2B, periodic data-ready interrupt with overrun flag.
module inert_sensor_model #(
    parameter int unsigned INT_PERIOD = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inert_sensor_model_if.slave   spi,
    output logic                  INT,
    output logic                  ovr,
    input  logic [15:0]           ptch_rt,
    input  logic [15:0]           roll_rt,
    input  logic [15:0]           yaw_rt,
    input  logic [15:0]           ax,
    input  logic [15:0]           ay
);
    localparam int unsigned    CW   = $clog2(INT_PERIOD);
    localparam logic [CW-1:0]  LAST = CW'(INT_PERIOD - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [2:0]  ss_sync, sclk_sync;
    logic [1:0]  mosi_sync;
    logic        ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;

    logic [0:0]  state;
    logic [4:0]  bit_cnt;
    logic [15:0] rx;
    logic [7:0]  tx;
    logic [7:0]  rd_data;

    logic [7:0]  cfg_0d, cfg_10, cfg_11, cfg_14;
    logic [7:0]  data_reg [10];

    logic [CW-1:0] cnt;
    logic        pending;
    logic        frame_done, wr_en, int_clr;
    logic        int_en, sample_evt, int_eff, evt_ok, evt_drop, service_req, service;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            ss_sync   <= {ss_sync[1:0], spi.SS_n};
            sclk_sync <= {sclk_sync[1:0], spi.SCLK};
            mosi_sync <= {mosi_sync[0], spi.MOSI};
        end
    end

    assign ss_fall   =  ss_sync[2]   & ~ss_sync[1];
    assign ss_rise   = ~ss_sync[2]   &  ss_sync[1];
    assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
    assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
    assign mosi_s    =  mosi_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
        end else if (ss_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
        end else if (state == SHIFT) begin
            if (ss_rise) begin
                state <= IDLE;
            end else if (sclk_rise) begin
                rx <= {rx[14:0], mosi_s};
                if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
            end else if (sclk_fall) begin
                // After the command byte, rx[6:0] holds the address
                tx <= (bit_cnt == 5'd8) ? rd_data : {tx[6:0], 1'b0};
            end
        end
    end

    assign spi.MISO = (state == SHIFT) ? tx[7] : 1'b0;

    always_comb begin
        rd_data = '0;
        case (rx[6:0])
            7'h0D: rd_data = cfg_0d;
            7'h10: rd_data = cfg_10;
            7'h11: rd_data = cfg_11;
            7'h14: rd_data = cfg_14;
            7'h22: rd_data = data_reg[0];
            7'h23: rd_data = data_reg[1];
            7'h24: rd_data = data_reg[2];
            7'h25: rd_data = data_reg[3];
            7'h26: rd_data = data_reg[4];
            7'h27: rd_data = data_reg[5];
            7'h28: rd_data = data_reg[6];
            7'h29: rd_data = data_reg[7];
            7'h2A: rd_data = data_reg[8];
            7'h2B: rd_data = data_reg[9];
            default: rd_data = '0;
        endcase
    end

    assign frame_done = (state == SHIFT) && ss_rise && (bit_cnt == 5'd16);
    assign wr_en      = frame_done && !rx[15];
    assign int_clr    = frame_done && rx[15] && (rx[14:8] == 7'h2B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_0d <= '0;
            cfg_10 <= '0;
            cfg_11 <= '0;
            cfg_14 <= '0;
        end else if (wr_en) begin
            case (rx[14:8])
                7'h0D: cfg_0d <= rx[7:0];
                7'h10: cfg_10 <= rx[7:0];
                7'h11: cfg_11 <= rx[7:0];
                7'h14: cfg_14 <= rx[7:0];
                default: ;
            endcase
        end
    end

    // An INT clear landing with a sample event frees the slot for that event
    assign int_en      = cfg_0d[1];
    assign sample_evt  = int_en && (cnt == LAST);
    assign int_eff     = INT && !int_clr;
    assign evt_ok      = sample_evt && !int_eff && !pending;
    assign evt_drop    = sample_evt && (int_eff || pending);
    assign service_req = pending || evt_ok;
    assign service     = service_req && (state != SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pending <= 1'b0;
            INT     <= 1'b0;
            ovr     <= 1'b0;
            for (int unsigned i = 0; i < 10; i++) data_reg[i] <= '0;
        end else begin
            if (!int_en || cnt == LAST) cnt <= '0;
            else                        cnt <= cnt + 1'b1;

            if (evt_drop) ovr <= 1'b1;

            if (service) begin
                data_reg[0] <= ptch_rt[7:0];
                data_reg[1] <= ptch_rt[15:8];
                data_reg[2] <= roll_rt[7:0];
                data_reg[3] <= roll_rt[15:8];
                data_reg[4] <= yaw_rt[7:0];
                data_reg[5] <= yaw_rt[15:8];
                data_reg[6] <= ax[7:0];
                data_reg[7] <= ax[15:8];
                data_reg[8] <= ay[7:0];
                data_reg[9] <= ay[15:8];
                INT         <= 1'b1;
                pending     <= 1'b0;
            end else begin
                if (service_req) pending <= 1'b1;
                if (int_clr)     INT     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_inert_sensor_model.sv
// Directed bench for the inertial sensor SPI model: config regs, snapshots, INT cadence, overrun.
module tb_inert_sensor_model;
    localparam int P = 3000;

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic        ovr;
    logic [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;

    inert_sensor_model_if spi_bus ();

    inert_sensor_model #(.INT_PERIOD(P)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .spi     (spi_bus),
        .INT     (INT),
        .ovr     (ovr),
        .ptch_rt (ptch_rt),
        .roll_rt (roll_rt),
        .yaw_rt  (yaw_rt),
        .ax      (ax),
        .ay      (ay)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int r_last = 0;

    logic [7:0] exp_data [10] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC,
                                  8'h9A, 8'hF0, 8'hDE, 8'h5A, 8'hA5};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [15:0] cmd, input int nbits, output logic [15:0] resp);
        resp = '0;
        spi_bus.SS_n = 1'b0;
        wait_clk(6);
        for (int i = 0; i < nbits; i++) begin
            spi_bus.SCLK = 1'b0;
            spi_bus.MOSI = cmd[4'(15 - i)];
            wait_clk(5);
            resp = {resp[14:0], spi_bus.MISO};
            spi_bus.SCLK = 1'b1;
            wait_clk(5);
        end
    endtask

    task automatic spi_end(output int k);
        wait_clk(5);
        spi_bus.SS_n = 1'b1;
        k = cyc;
    endtask

    task automatic spi_xfer(input logic [15:0] cmd, output logic [15:0] resp);
        int k;
        spi_bits(cmd, 16, resp);
        spi_end(k);
        wait_clk(8);
    endtask

    task automatic spi_read(input logic [6:0] addr, output logic [15:0] resp);
        spi_xfer({1'b1, addr, 8'h00}, resp);
    endtask

    task automatic wait_rise(input int budget, output int at, output bit ok);
        logic prev;
        ok = 1'b0;
        at = 0;
        prev = INT;
        for (int i = 0; i < budget; i++) begin
            wait_clk(1);
            if (INT && !prev) begin
                at = cyc;
                ok = 1'b1;
                break;
            end
            prev = INT;
        end
    endtask

    task automatic test_reset;
        logic [15:0] r;
        int k;
        rst_n = 1'b0;
        spi_bus.SS_n = 1'b1;
        spi_bus.SCLK = 1'b1;
        spi_bus.MOSI = 1'b0;
        wait_clk(4);
        checks++; if (spi_bus.MISO !== 1'b0) begin errors++; $display("FAIL rst_miso got %b exp 0", spi_bus.MISO); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL rst_int got %b exp 0", INT); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", ovr); end
        rst_n = 1'b1;
        wait_clk(4);
        spi_read(7'h0D, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rst_reg0d got %h exp 0000", r); end
        spi_read(7'h22, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rst_reg22 got %h exp 0000", r); end
        spi_bits(16'h1077, 16, r);
        rst_n = 1'b0;
        wait_clk(2);
        checks++; if (spi_bus.MISO !== 1'b0) begin errors++; $display("FAIL midrst_miso got %b exp 0", spi_bus.MISO); end
        rst_n = 1'b1;
        wait_clk(3);
        spi_end(k);
        wait_clk(8);
        spi_read(7'h10, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL midrst_reg10 got %h exp 0000", r); end
    endtask

    task automatic test_config;
        logic [15:0] r;
        int k0, at;
        bit ok;
        spi_bits(16'h0D02, 16, r);
        spi_end(k0);
        wait_clk(8);
        spi_xfer(16'h1062, r);
        spi_xfer(16'h1162, r);
        spi_xfer(16'h1460, r);
        spi_read(7'h0D, r);
        checks++; if (r !== 16'h0002) begin errors++; $display("FAIL cfg_0d got %h exp 0002", r); end
        spi_read(7'h10, r);
        checks++; if (r !== 16'h0062) begin errors++; $display("FAIL cfg_10 got %h exp 0062", r); end
        spi_read(7'h11, r);
        checks++; if (r !== 16'h0062) begin errors++; $display("FAIL cfg_11 got %h exp 0062", r); end
        spi_read(7'h14, r);
        checks++; if (r !== 16'h0060) begin errors++; $display("FAIL cfg_14 got %h exp 0060", r); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL cfg_int_early got %b exp 0", INT); end
        wait_rise(P + 500, at, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cfg_int_timeout got %b exp 1", ok); end
        checks++; if (at !== k0 + 3 + P) begin errors++; $display("FAIL cfg_int_time got %0d exp %0d", at, k0 + 3 + P); end
    endtask

    task automatic test_data;
        logic [15:0] r;
        logic [6:0] a;
        int k;
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL data_int got %b exp 1", INT); end
        for (int i = 0; i < 9; i++) begin
            a = 7'h22 + 7'(i);
            spi_read(a, r);
            checks++;
            if (r !== {8'h00, exp_data[i]}) begin
                errors++; $display("FAIL data_reg%h got %h exp %h", a, r, {8'h00, exp_data[i]});
            end
        end
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL data_int_held got %b exp 1", INT); end
        spi_bits(16'hAB00, 16, r);
        checks++; if (r !== 16'h00A5) begin errors++; $display("FAIL data_reg2b got %h exp 00a5", r); end
        spi_end(k);
        wait_clk(2);
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL data_int_before_clr got %b exp 1", INT); end
        wait_clk(1);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL data_int_clr got %b exp 0", INT); end
        wait_clk(8);
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL data_ovr got %b exp 0", ovr); end
    endtask

    task automatic test_readonly;
        logic [15:0] r;
        spi_xfer(16'h2299, r);
        spi_xfer(16'h3377, r);
        spi_read(7'h22, r);
        checks++; if (r !== 16'h0034) begin errors++; $display("FAIL ro_reg22 got %h exp 0034", r); end
        spi_read(7'h33, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL ro_reg33 got %h exp 0000", r); end
    endtask

    task automatic test_abort;
        logic [15:0] r;
        int k, rr, at;
        bit ok;
        if (INT) spi_read(7'h2B, r);
        wait_rise(P + 500, rr, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_sync_timeout got %b exp 1", ok); end
        spi_read(7'h2B, r);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL abort_int_clr got %b exp 0", INT); end
        spi_bits(16'h0D00, 9, r);
        spi_end(k);
        wait_clk(8);
        spi_read(7'h0D, r);
        checks++; if (r !== 16'h0002) begin errors++; $display("FAIL abort_reg0d got %h exp 0002", r); end
        wait_rise(P + 500, at, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_int_timeout got %b exp 1", ok); end
        checks++; if (at !== rr + P) begin errors++; $display("FAIL abort_cadence got %0d exp %0d", at, rr + P); end
        r_last = at;
    endtask

    task automatic test_overrun;
        logic [15:0] r;
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_pre got %b exp 0", ovr); end
        ptch_rt = 16'hBEEF;
        roll_rt = 16'h1111;
        yaw_rt  = 16'h2222;
        ax      = 16'h3333;
        ay      = 16'h4444;
        wait_clk(2 * P + 10);
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", ovr); end
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL ovr_int got %b exp 1", INT); end
        spi_read(7'h22, r);
        checks++; if (r !== 16'h0034) begin errors++; $display("FAIL ovr_reg22 got %h exp 0034", r); end
        spi_read(7'h2B, r);
        checks++; if (r !== 16'h00A5) begin errors++; $display("FAIL ovr_reg2b got %h exp 00a5", r); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL ovr_int_clr got %b exp 0", INT); end
    endtask

    task automatic test_mid_frame;
        logic [15:0] r;
        int e, k;
        e = r_last + P;
        while (e < cyc + 100) e += P;
        while (cyc < e - 80) wait_clk(1);
        spi_bits(16'hA200, 16, r);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mid_int_deferred got %b exp 0", INT); end
        checks++; if (r !== 16'h0034) begin errors++; $display("FAIL mid_old_data got %h exp 0034", r); end
        spi_end(k);
        wait_clk(3);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mid_int_early got %b exp 0", INT); end
        wait_clk(1);
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL mid_int_rise got %b exp 1", INT); end
        wait_clk(8);
        spi_read(7'h22, r);
        checks++; if (r !== 16'h00EF) begin errors++; $display("FAIL mid_reg22 got %h exp 00ef", r); end
        spi_read(7'h23, r);
        checks++; if (r !== 16'h00BE) begin errors++; $display("FAIL mid_reg23 got %h exp 00be", r); end
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL mid_ovr got %b exp 1", ovr); end
    endtask

    initial begin
        ptch_rt = 16'h1234;
        roll_rt = 16'h5678;
        yaw_rt  = 16'h9ABC;
        ax      = 16'hDEF0;
        ay      = 16'hA55A;
        test_reset();
        test_config();
        test_data();
        test_readonly();
        test_abort();
        test_overrun();
        test_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
